// File: rtl/mmss_bcd_timer.sv
// MM:SS BCD stopwatch core: IDLE/RUN/PAUSE control, second prescaler and a four-digit BCD count.
// Optional display hold (lap snapshot) is built when LAP_HOLD_EN is defined.
module mmss_bcd_timer #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
`ifdef LAP_HOLD_EN
  input  logic       lap,
`endif
  output logic [3:0] units_second,
  output logic [3:0] tens_second,
  output logic [3:0] units_minute,
  output logic [3:0] tens_minute,
  output logic       running,
  output logic       sec_tick,
  output logic       rollover
);

  localparam int PW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] pre_r;
  logic [3:0]    us_r, ts_r, um_r, tm_r;
  logic [3:0]    us_s, ts_s, um_s, tm_s;
  logic [4:0]    inc_us_s, inc_ts_s, inc_um_s, inc_tm_s;
  logic          adv_s, terminal_s, carry_ts_s, carry_um_s, carry_tm_s, wrap_s;
  logic          running_r, sec_tick_r, rollover_r;

  // Saturating-safe BCD step: returns {carry, next digit}; anything at or above max wraps to 0.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
    if (d >= max) begin
      bcd_inc = {1'b1, 4'd0};
    end else begin
      bcd_inc = {1'b0, d + 4'd1};
    end
  endfunction

  // Next-state logic; clear beats stop beats start.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = IDLE;
    end else if (stop) begin
      if (state_r == RUN) begin
        state_s = PAUSE;
      end else begin
        state_s = state_r;
      end
    end else if (start) begin
      if (state_r != RUN) begin
        state_s = RUN;
      end else begin
        state_s = state_r;
      end
    end else begin
      state_s = state_r;
    end
  end

  // A stop or clear arriving on the terminal prescaler count suppresses that increment.
  assign adv_s      = (state_r == RUN) && !stop && !clear;
  assign terminal_s = adv_s && (pre_r == PRE_LAST);

  assign inc_us_s   = bcd_inc(us_r, 4'd9);
  assign inc_ts_s   = bcd_inc(ts_r, 4'd5);
  assign inc_um_s   = bcd_inc(um_r, 4'd9);
  assign inc_tm_s   = bcd_inc(tm_r, 4'd5);
  assign carry_ts_s = terminal_s && inc_us_s[4];
  assign carry_um_s = carry_ts_s && inc_ts_s[4];
  assign carry_tm_s = carry_um_s && inc_um_s[4];
  assign wrap_s     = carry_tm_s && inc_tm_s[4];

  assign us_s = terminal_s ? inc_us_s[3:0] : us_r;
  assign ts_s = carry_ts_s ? inc_ts_s[3:0] : ts_r;
  assign um_s = carry_um_s ? inc_um_s[3:0] : um_r;
  assign tm_s = carry_tm_s ? inc_tm_s[3:0] : tm_r;

  // State, prescaler, live digits and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pre_r      <= {PW{1'b0}};
      us_r       <= 4'd0;
      ts_r       <= 4'd0;
      um_r       <= 4'd0;
      tm_r       <= 4'd0;
      running_r  <= 1'b0;
      sec_tick_r <= 1'b0;
      rollover_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      running_r  <= (state_s == RUN);
      sec_tick_r <= terminal_s;
      rollover_r <= wrap_s;
      if (clear) begin
        pre_r <= {PW{1'b0}};
        us_r  <= 4'd0;
        ts_r  <= 4'd0;
        um_r  <= 4'd0;
        tm_r  <= 4'd0;
      end else begin
        if (terminal_s) begin
          pre_r <= {PW{1'b0}};
        end else if (adv_s) begin
          pre_r <= pre_r + PW'(1);
        end
        us_r <= us_s;
        ts_r <= ts_s;
        um_r <= um_s;
        tm_r <= tm_s;
      end
    end
  end

  assign running  = running_r;
  assign sec_tick = sec_tick_r;
  assign rollover = rollover_r;

`ifdef LAP_HOLD_EN
  logic       hold_r, hold_s, lap_tog_s;
  logic [3:0] dus_r, dts_r, dum_r, dtm_r;

  assign lap_tog_s = lap && !clear && (state_r != IDLE);
  assign hold_s    = lap_tog_s ? !hold_r : hold_r;

  // Display registers: freeze the value on screen when hold engages, otherwise follow live time.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= 1'b0;
      dus_r  <= 4'd0;
      dts_r  <= 4'd0;
      dum_r  <= 4'd0;
      dtm_r  <= 4'd0;
    end else if (clear) begin
      hold_r <= 1'b0;
      dus_r  <= 4'd0;
      dts_r  <= 4'd0;
      dum_r  <= 4'd0;
      dtm_r  <= 4'd0;
    end else begin
      hold_r <= hold_s;
      if (hold_s && !hold_r) begin
        dus_r <= us_r;
        dts_r <= ts_r;
        dum_r <= um_r;
        dtm_r <= tm_r;
      end else if (!hold_s) begin
        dus_r <= us_s;
        dts_r <= ts_s;
        dum_r <= um_s;
        dtm_r <= tm_s;
      end
    end
  end

  assign units_second = dus_r;
  assign tens_second  = dts_r;
  assign units_minute = dum_r;
  assign tens_minute  = dtm_r;
`else
  assign units_second = us_r;
  assign tens_second  = ts_r;
  assign units_minute = um_r;
  assign tens_minute  = tm_r;
`endif

endmodule
